alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
Initiator side of the multi-cycle ALU valid/ready interface (modes 0 mulu, 1 divu, 2 and, 3 avg).
- Accepts tagged commands from upstream into a small FIFO.
- Issues them to the ALU one at a time with a one-cycle alu_valid pulse, then waits for alu_ready.
- Captures the 64-bit result and presents it downstream with a res_valid/res_ready handshake.
- Sits between the control sequencer and the ALU.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, minimum 2.
TAG_W, 4, width of the command tag carried through to the result.
TIMEOUT, 64, cycles in WAIT before abort; used only with ALU_TIMEOUT_EN.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
cmd_valid  in  1  upstream command present.
cmd_ready  out  1  FIFO can accept a command.
cmd_mode  in  2  ALU mode.
cmd_a  in  32  operand A.
cmd_b  in  32  operand B.
cmd_tag  in  TAG_W  tag echoed on the result.
alu_valid  out  1  one-cycle issue pulse to the ALU.
alu_mode  out  2  mode for the issued op.
alu_in_A  out  32  operand A for the issued op.
alu_in_B  out  32  operand B for the issued op.
alu_ready  in  1  ALU result strobe; alu_out is valid only in this cycle.
alu_out  in  64  ALU result.
res_valid  out  1  result available.
res_ready  in  1  downstream accepts the result.
res_data  out  64  captured result.
res_tag  out  TAG_W  tag of the result.
res_mode  out  2  mode of the result.
res_err  out  1  timeout flag; tied 0 when ALU_TIMEOUT_EN is not defined.
busy  out  1  1 when FSM is not IDLE or FIFO is not empty.
count  out  $clog2(DEPTH)+1  number of FIFO entries; excludes the in-flight op.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs go to 0, FIFO empty, FSM in IDLE.
- Reset mid-operation discards the in-flight op and all queued commands. The ALU shares rst_n, so both ends restart together.
- FIFO:
  - Push when cmd_valid && cmd_ready. cmd_ready = (count != DEPTH), registered and independent of a same-cycle pop.
  - Push and pop in the same cycle: count is unchanged.
  - Read/write pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - If count != 0: pop the head into the op registers (mode/a/b/tag) and go to ISSUE.
  - A command pushed at cycle T is popped no earlier than T+1.
- ISSUE:
  - alu_valid = 1 for exactly this cycle; alu_mode/alu_in_A/alu_in_B carry the op registers. Go to WAIT.
  - alu_valid is a registered output and is never high in two consecutive cycles.
- WAIT:
  - alu_valid = 0. On alu_ready = 1: res_data <= alu_out, res_tag/res_mode from the op registers, res_err <= 0. Go to HOLD.
  - res_valid rises the cycle after alu_ready.
- HOLD:
  - res_valid = 1; res_* stay stable until res_ready.
  - On res_valid && res_ready: res_valid drops next cycle, go to IDLE.
  - Back-to-back ops: the next alu_valid is no sooner than 2 cycles after result acceptance (HOLD->IDLE->ISSUE).
- alu_in_A/alu_in_B/alu_mode hold the last issued op's values until the next ISSUE.
- alu_ready in any state other than WAIT is ignored and dropped.
- At most one op is outstanding at the ALU at any time.
- The FIFO keeps accepting commands in every FSM state while not full.

Optional Feature:
ALU_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no alu_ready: go to HOLD with res_err = 1, res_data = 0, res_tag/res_mode of the op.
  - alu_ready arriving in the same cycle as the timeout wins (normal result).
  - A late alu_ready after abort is dropped; recovery beyond that is via rst_n.
- Not defined: no counter; WAIT lasts indefinitely; res_err is constant 0.

Test Plan:
1. Reset, then push mode 2, a=32'hF0F0_00FF, b=32'h0FF0_FF0F, tag 3. Bench ALU returns 64'h0000_0000_00F0_000F two cycles after alu_valid -> one alu_valid pulse carrying those operands; res_valid the cycle after alu_ready with res_data=64'h00F0_000F, res_tag=3, res_mode=2.
2. Push 5 commands back-to-back (tags 0..4, DEPTH=4) while ALU latency is 33 cycles -> cmd_ready drops at count=4; issue order, alu_valid operands, and res_tag sequence are 0,1,2,3,4 exactly in order.
3. Hold res_ready=0 for 10 cycles after a mode 0 result 64'd15 (3*5) -> res_valid and res_data stay stable, no new alu_valid; after res_ready=1, next alu_valid is exactly 2 cycles later.
4. Spurious alu_ready in IDLE and in HOLD -> no change to res_* or FSM state.
5. Assert rst_n=0 in WAIT with 3 entries queued -> all outputs 0, count=0 immediately; after release, no alu_valid until a new push.
6. With ALU_TIMEOUT_EN and TIMEOUT=64, ALU never answers -> res_valid 1 cycle after the 64th WAIT cycle with res_err=1, res_data=0. Repeat with alu_ready=1 in the 64th cycle -> normal result, res_err=0.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues tagged ALU commands in a small FIFO, issues them one
// at a time to a multi-cycle ALU (one-cycle alu_valid pulse, wait for
// alu_ready) and returns each result downstream with a valid/ready handshake.
// Optional feature macro: ALU_TIMEOUT_EN aborts a WAIT lasting TIMEOUT cycles.
module alu_cmd_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_mode,
  input  logic [31:0]            cmd_a,
  input  logic [31:0]            cmd_b,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic                   alu_valid,
  output logic [1:0]             alu_mode,
  output logic [31:0]            alu_in_A,
  output logic [31:0]            alu_in_B,
  input  logic                   alu_ready,
  input  logic [63:0]            alu_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [63:0]            res_data,
  output logic [TAG_W-1:0]       res_tag,
  output logic [1:0]             res_mode,
  output logic                   res_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = TAG_W + 66;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  state_e state_q, state_d;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             push, pop;
  logic [EW-1:0]    head;

  logic             alu_valid_q, alu_valid_d;
  logic [1:0]       alu_mode_q, alu_mode_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [TAG_W-1:0] op_tag_q, op_tag_d;

  logic             res_valid_q, res_valid_d;
  logic [63:0]      res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [1:0]       res_mode_q, res_mode_d;

  logic             timeout_hit;
  logic             wait_done;

  assign push      = cmd_valid && cmd_ready_q;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign wait_done = (state_q == WAIT) && (alu_ready || timeout_hit);

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_tag, cmd_mode, cmd_a, cmd_b};
  end

  // FIFO pointer/occupancy next state; cmd_ready is registered from next count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    cmd_ready_d = (count_d != CW'(DEPTH));
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (alu_ready || timeout_hit) state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: op registers load on pop, result registers load on WAIT exit
  always_comb begin
    alu_valid_d = (state_d == ISSUE);
    alu_mode_d  = alu_mode_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    op_tag_d    = op_tag_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    res_mode_d  = res_mode_q;
    if (pop) begin
      {op_tag_d, alu_mode_d, alu_a_d, alu_b_d} = head;
    end
    if (wait_done) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_ready ? alu_out : '0;
      res_tag_d   = op_tag_q;
      res_mode_d  = alu_mode_q;
    end else if ((state_q == HOLD) && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // Issue and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid_q <= 1'b0;
      alu_mode_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      op_tag_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_mode_q  <= '0;
    end else begin
      alu_valid_q <= alu_valid_d;
      alu_mode_q  <= alu_mode_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      op_tag_q    <= op_tag_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_mode_q  <= res_mode_d;
    end
  end

`ifdef ALU_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          res_err_q, res_err_d;

  // Value during the k-th WAIT cycle is k-1, so the abort fires in cycle TIMEOUT
  assign timeout_hit = (state_q == WAIT) && !alu_ready &&
                       (wait_cnt_q == TW'(TIMEOUT - 1));

  // Wait counter and error flag next state
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    res_err_d  = res_err_q;
    if (state_q == WAIT)      wait_cnt_d = wait_cnt_q + 1'b1;
    else if (state_d == WAIT) wait_cnt_d = '0;
    if (wait_done) res_err_d = !alu_ready;
  end

  // Wait counter and error flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      res_err_q  <= res_err_d;
    end
  end

  assign res_err = res_err_q;
`else
  assign timeout_hit = 1'b0;
  assign res_err     = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign alu_valid = alu_valid_q;
  assign alu_mode  = alu_mode_q;
  assign alu_in_A  = alu_a_q;
  assign alu_in_B  = alu_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign res_mode  = res_mode_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);
  assign count     = count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: a behavioural ALU responder plus a
// command scoreboard; define ALU_TIMEOUT_EN to also exercise the abort path.
`timescale 1ns/1ps
module tb_alu_cmd_issuer;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_mode = '0;
  logic [31:0]      cmd_a = '0;
  logic [31:0]      cmd_b = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic             alu_valid;
  logic [1:0]       alu_mode;
  logic [31:0]      alu_in_A;
  logic [31:0]      alu_in_B;
  logic             alu_ready = 1'b0;
  logic [63:0]      alu_out = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [63:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic [1:0]       res_mode;
  logic             res_err;
  logic             busy;
  logic [CW-1:0]    count;

  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_valid(alu_valid), .alu_mode(alu_mode), .alu_in_A(alu_in_A), .alu_in_B(alu_in_B),
    .alu_ready(alu_ready), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_mode(res_mode), .res_err(res_err),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] mode; logic [31:0] a; logic [31:0] b; logic [TAG_W-1:0] tag; } cmd_t;
  typedef struct { int unsigned cyc; logic [1:0] mode; logic [31:0] a; logic [31:0] b; } iss_t;
  typedef struct { int unsigned cyc; logic [63:0] data; logic [TAG_W-1:0] tag; logic [1:0] mode; logic err; } res_t;

  cmd_t exp_q[$];
  iss_t iss_q[$];
  res_t res_q[$];

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  int unsigned viol_consec = 0;
  int unsigned viol_inflight = 0;

  logic        prev_valid = 1'b0;
  logic        inflight = 1'b0;
  logic        pend = 1'b0;
  int unsigned pcnt = 0;
  logic [63:0] pres = '0;
  int unsigned alu_lat = 2;
  logic        alu_rand = 1'b0;
  logic        spur = 1'b0;
  logic [63:0] spur_data = '0;

  function automatic logic [63:0] alu_model(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    case (m)
      2'd0:    return {32'd0, a} * {32'd0, b};
      2'd1:    return (b == 32'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : {a % b, a / b};
      2'd2:    return {32'd0, a & b};
      default: return ({32'd0, a} + {32'd0, b}) >> 1;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // Observer and ALU request capture, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_valid) begin
        if (prev_valid) viol_consec++;
        if (inflight) viol_inflight++;
        inflight = 1'b1;
        iss_q.push_back('{cyc, alu_mode, alu_in_A, alu_in_B});
        pcnt = alu_rand ? $urandom_range(6, 1) : alu_lat;
        pend = (pcnt != 0);
        pres = alu_model(alu_mode, alu_in_A, alu_in_B);
      end
      if (res_valid && res_ready) begin
        res_q.push_back('{cyc, res_data, res_tag, res_mode, res_err});
        inflight = 1'b0;
      end
      prev_valid = alu_valid;
    end else begin
      prev_valid = 1'b0;
      inflight   = 1'b0;
      pend       = 1'b0;
    end
  end

  // Behavioural ALU: answers pcnt cycles after the issue pulse; spur forces a stray strobe
  always @(posedge clk) begin
    #2;
    alu_ready = 1'b0;
    if (pend) begin
      if (pcnt <= 1) begin
        alu_ready = 1'b1;
        alu_out   = pres;
        pend      = 1'b0;
      end else begin
        pcnt--;
      end
    end
    if (spur) begin
      alu_ready = 1'b1;
      alu_out   = spur_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    iss_q.delete();
    res_q.delete();
  endtask

  task automatic push_cmd(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    int unsigned n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = t;
    while (!cmd_ready && n < 300) begin
      tick();
      n++;
    end
    n_chk++;
    if (!cmd_ready) $display("FAIL push_accept: cmd_ready=%b required 1 within 300 cycles", cmd_ready);
    else begin
      n_pass++;
      exp_q.push_back('{m, a, b, t});
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input int unsigned n, input int unsigned budget);
    int unsigned k;
    k = 0;
    while (res_q.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({cmd_ready, alu_valid, res_valid, res_err, busy} !== 5'b0)
      $display("FAIL reset_flags: got %b required 00000", {cmd_ready, alu_valid, res_valid, res_err, busy});
    else n_pass++;
    n_chk++;
    if (count !== '0) $display("FAIL reset_count: got %0d required 0", count);
    else n_pass++;
    n_chk++;
    if ({alu_mode, alu_in_A, alu_in_B} !== 66'd0)
      $display("FAIL reset_alu_ops: got %h required 0", {alu_mode, alu_in_A, alu_in_B});
    else n_pass++;
    n_chk++;
    if ({res_data, res_tag, res_mode} !== '0)
      $display("FAIL reset_res: got %h required 0", {res_data, res_tag, res_mode});
    else n_pass++;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    n_chk++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    else n_pass++;
    clear_logs();
  endtask

  task automatic test_single();
    logic [31:0] a, b;
    a = 32'hF0F0_00FF;
    b = 32'h0FF0_FF0F;
    clear_logs();
    alu_lat   = 2;
    res_ready = 1'b1;
    push_cmd(2'd2, a, b, 4'd3);
    wait_res(1, 50);
    n_chk++;
    if (res_q.size() != 1 || iss_q.size() != 1)
      $display("FAIL single_counts: results=%0d issues=%0d required 1/1", res_q.size(), iss_q.size());
    else begin
      n_pass++;
      n_chk++;
      if (iss_q[0].mode !== 2'd2 || iss_q[0].a !== a || iss_q[0].b !== b)
        $display("FAIL single_issue: got %0d/%h/%h required 2/%h/%h", iss_q[0].mode, iss_q[0].a, iss_q[0].b, a, b);
      else n_pass++;
      n_chk++;
      if (res_q[0].data !== 64'h0000_0000_00F0_000F)
        $display("FAIL single_data: got %h required 00000000_00f0000f", res_q[0].data);
      else n_pass++;
      n_chk++;
      if (res_q[0].tag !== 4'd3 || res_q[0].mode !== 2'd2 || res_q[0].err !== 1'b0)
        $display("FAIL single_tag_mode: got %0d/%0d/%b required 3/2/0", res_q[0].tag, res_q[0].mode, res_q[0].err);
      else n_pass++;
      n_chk++;
      if (res_q[0].cyc != iss_q[0].cyc + 3)
        $display("FAIL single_latency: res_valid at cycle %0d required %0d", res_q[0].cyc, iss_q[0].cyc + 3);
      else n_pass++;
    end
    repeat (3) tick();
    n_chk++;
    if (alu_in_A !== a || alu_in_B !== b || alu_mode !== 2'd2)
      $display("FAIL single_ops_hold: got %h/%h/%0d required %h/%h/2", alu_in_A, alu_in_B, alu_mode, a, b);
    else n_pass++;
  endtask

  task automatic test_fill_order();
    clear_logs();
    alu_lat   = 33;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      push_cmd(2'($urandom_range(3, 0)), $urandom, $urandom, TAG_W'(i));
    n_chk++;
    if (count !== CW'(DEPTH)) $display("FAIL fill_count: got %0d required %0d", count, DEPTH);
    else n_pass++;
    n_chk++;
    if (cmd_ready !== 1'b0) $display("FAIL fill_ready: got %b required 0", cmd_ready);
    else n_pass++;
    wait_res(5, 300);
    n_chk++;
    if (res_q.size() != 5 || iss_q.size() != 5 || exp_q.size() != 5)
      $display("FAIL fill_counts: results=%0d issues=%0d required 5/5", res_q.size(), iss_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if (iss_q[i].mode !== exp_q[i].mode || iss_q[i].a !== exp_q[i].a || iss_q[i].b !== exp_q[i].b)
          $display("FAIL fill_issue[%0d]: got %0d/%h/%h required %0d/%h/%h", i,
                   iss_q[i].mode, iss_q[i].a, iss_q[i].b, exp_q[i].mode, exp_q[i].a, exp_q[i].b);
        else n_pass++;
        n_chk++;
        if (res_q[i].tag !== TAG_W'(i) || res_q[i].data !== alu_model(exp_q[i].mode, exp_q[i].a, exp_q[i].b))
          $display("FAIL fill_result[%0d]: got tag %0d data %h required tag %0d data %h", i,
                   res_q[i].tag, res_q[i].data, i, alu_model(exp_q[i].mode, exp_q[i].a, exp_q[i].b));
        else n_pass++;
      end
    end
    n_chk++;
    if (viol_consec != 0 || viol_inflight != 0)
      $display("FAIL fill_one_outstanding: consecutive=%0d overlapping=%0d required 0/0", viol_consec, viol_inflight);
    else n_pass++;
  endtask

  task automatic test_hold();
    int unsigned stable, k, t;
    logic [31:0] a2, b2;
    clear_logs();
    alu_lat   = 3;
    res_ready = 1'b0;
    a2 = $urandom;
    b2 = $urandom;
    push_cmd(2'd0, 32'd3, 32'd5, 4'd7);
    push_cmd(2'd3, a2, b2, 4'd8);
    k = 0;
    @(negedge clk);
    while (!res_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1 && res_data === 64'd15 && res_tag === 4'd7) stable++;
    end
    n_chk++;
    if (stable != 10) $display("FAIL hold_stable: stable cycles %0d required 10", stable);
    else n_pass++;
    n_chk++;
    if (iss_q.size() != 1) $display("FAIL hold_no_issue: issues %0d required 1", iss_q.size());
    else n_pass++;
    tick();
    t = cyc;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    k = 0;
    while (iss_q.size() < 2 && k < 20) begin
      tick();
      k++;
    end
    n_chk++;
    if (iss_q.size() < 2 || iss_q[1].cyc != t + 2)
      $display("FAIL hold_reissue: next issue count %0d cycle %0d required cycle %0d",
               iss_q.size(), (iss_q.size() < 2) ? 0 : iss_q[1].cyc, t + 2);
    else n_pass++;
    res_ready = 1'b1;
    wait_res(2, 50);
    n_chk++;
    if (res_q.size() != 2 || res_q[0].data !== 64'd15 || res_q[1].tag !== 4'd8 ||
        res_q[1].data !== alu_model(2'd3, a2, b2))
      $display("FAIL hold_results: count %0d second tag %0d data %h required 2/8/%h", res_q.size(),
               (res_q.size() < 2) ? 0 : res_q[1].tag, (res_q.size() < 2) ? 64'd0 : res_q[1].data,
               alu_model(2'd3, a2, b2));
    else n_pass++;
  endtask

  task automatic test_spurious();
    logic [31:0] a, b;
    logic [63:0] exp_data;
    clear_logs();
    alu_lat   = 2;
    res_ready = 1'b1;
    a = $urandom;
    b = $urandom;
    push_cmd(2'd0, a, b, 4'd1);
    wait_res(1, 50);
    repeat (3) tick();
    spur_data = {$urandom, $urandom};
    spur = 1'b1;
    tick();
    spur = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== alu_model(2'd0, a, b) || res_q.size() != 1 || iss_q.size() != 1)
      $display("FAIL spur_idle: res_valid=%b busy=%b data=%h results=%0d required 0/0/%h/1",
               res_valid, busy, res_data, res_q.size(), alu_model(2'd0, a, b));
    else n_pass++;
    res_ready = 1'b0;
    a = $urandom;
    b = $urandom;
    exp_data = alu_model(2'd2, a, b);
    push_cmd(2'd2, a, b, 4'd9);
    repeat (8) tick();
    spur_data = ~exp_data;
    spur = 1'b1;
    repeat (2) tick();
    spur = 1'b0;
    tick();
    n_chk++;
    if (res_valid !== 1'b1 || res_data !== exp_data || res_tag !== 4'd9 || res_mode !== 2'd2)
      $display("FAIL spur_hold: valid=%b data=%h tag=%0d mode=%0d required 1/%h/9/2",
               res_valid, res_data, res_tag, res_mode, exp_data);
    else n_pass++;
    res_ready = 1'b1;
    wait_res(2, 20);
    repeat (3) tick();
    n_chk++;
    if (res_q.size() != 2 || iss_q.size() != 2 || busy !== 1'b0)
      $display("FAIL spur_drain: results=%0d issues=%0d busy=%b required 2/2/0", res_q.size(), iss_q.size(), busy);
    else n_pass++;
  endtask

  task automatic test_random();
    int unsigned k;
    localparam int unsigned N = 40;
    clear_logs();
    alu_rand = 1'b1;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          push_cmd(2'($urandom_range(3, 0)), $urandom, $urandom, TAG_W'($urandom));
          repeat ($urandom_range(2, 0)) tick();
        end
      end
      begin
        k = 0;
        while (res_q.size() < N && k < 3000) begin
          res_ready = 1'($urandom_range(1, 0));
          tick();
          k++;
        end
        res_ready = 1'b1;
      end
    join
    wait_res(N, 200);
    alu_rand = 1'b0;
    n_chk++;
    if (res_q.size() != N || iss_q.size() != N || exp_q.size() != N)
      $display("FAIL rand_counts: results=%0d issues=%0d required %0d", res_q.size(), iss_q.size(), N);
    else begin
      n_pass++;
      for (int i = 0; i < N; i++) begin
        n_chk++;
        if (iss_q[i].mode !== exp_q[i].mode || iss_q[i].a !== exp_q[i].a || iss_q[i].b !== exp_q[i].b)
          $display("FAIL rand_issue[%0d]: got %0d/%h/%h required %0d/%h/%h", i,
                   iss_q[i].mode, iss_q[i].a, iss_q[i].b, exp_q[i].mode, exp_q[i].a, exp_q[i].b);
        else n_pass++;
        n_chk++;
        if (res_q[i].tag !== exp_q[i].tag || res_q[i].mode !== exp_q[i].mode || res_q[i].err !== 1'b0 ||
            res_q[i].data !== alu_model(exp_q[i].mode, exp_q[i].a, exp_q[i].b))
          $display("FAIL rand_result[%0d]: got %0d/%0d/%b/%h required %0d/%0d/0/%h", i,
                   res_q[i].tag, res_q[i].mode, res_q[i].err, res_q[i].data,
                   exp_q[i].tag, exp_q[i].mode, alu_model(exp_q[i].mode, exp_q[i].a, exp_q[i].b));
        else n_pass++;
      end
    end
    n_chk++;
    if (viol_consec != 0 || viol_inflight != 0)
      $display("FAIL rand_one_outstanding: consecutive=%0d overlapping=%0d required 0/0", viol_consec, viol_inflight);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_logs();
    alu_lat   = 0;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      push_cmd(2'($urandom_range(3, 0)), $urandom, $urandom, TAG_W'(i));
    repeat (2) tick();
    n_chk++;
    if (count !== CW'(3) || iss_q.size() != 1)
      $display("FAIL rstmid_pre: count=%0d issues=%0d required 3/1", count, iss_q.size());
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({cmd_ready, alu_valid, res_valid, res_err, busy} !== 5'b0 || count !== '0 ||
        {alu_mode, alu_in_A, alu_in_B, res_data, res_tag, res_mode} !== '0)
      $display("FAIL rstmid_async: flags=%b count=%0d required 00000/0",
               {cmd_ready, alu_valid, res_valid, res_err, busy}, count);
    else n_pass++;
    repeat (2) tick();
    rst_n = 1'b1;
    clear_logs();
    repeat (10) tick();
    n_chk++;
    if (iss_q.size() != 0 || busy !== 1'b0 || count !== '0 || cmd_ready !== 1'b1)
      $display("FAIL rstmid_after: issues=%0d busy=%b count=%0d ready=%b required 0/0/0/1",
               iss_q.size(), busy, count, cmd_ready);
    else n_pass++;
  endtask

`ifdef ALU_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] a, b;
    clear_logs();
    alu_lat   = 0;
    res_ready = 1'b1;
    push_cmd(2'd1, $urandom, $urandom, 4'd5);
    wait_res(1, 200);
    n_chk++;
    if (res_q.size() != 1 || iss_q.size() != 1 || res_q[0].err !== 1'b1 || res_q[0].data !== 64'd0 ||
        res_q[0].tag !== 4'd5 || res_q[0].mode !== 2'd1 || res_q[0].cyc != iss_q[0].cyc + TIMEOUT + 1)
      $display("FAIL timeout_abort: results=%0d err=%b data=%h cycle %0d required 1/1/0/%0d", res_q.size(),
               (res_q.size() < 1) ? 1'b0 : res_q[0].err, (res_q.size() < 1) ? 64'd0 : res_q[0].data,
               (res_q.size() < 1) ? 0 : res_q[0].cyc, (iss_q.size() < 1) ? 0 : iss_q[0].cyc + TIMEOUT + 1);
    else n_pass++;
    alu_lat = TIMEOUT;
    a = $urandom;
    b = $urandom;
    push_cmd(2'd3, a, b, 4'd6);
    wait_res(2, 200);
    n_chk++;
    if (res_q.size() != 2 || iss_q.size() != 2 || res_q[1].err !== 1'b0 || res_q[1].data !== alu_model(2'd3, a, b) ||
        res_q[1].tag !== 4'd6 || res_q[1].cyc != iss_q[1].cyc + TIMEOUT + 1)
      $display("FAIL timeout_race: results=%0d err=%b data=%h required 2/0/%h", res_q.size(),
               (res_q.size() < 2) ? 1'b1 : res_q[1].err, (res_q.size() < 2) ? 64'd0 : res_q[1].data,
               alu_model(2'd3, a, b));
    else n_pass++;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill_order();
    test_hold();
    test_spurious();
    test_random();
    test_reset_mid();
`ifdef ALU_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
